// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the single MFA/MFC RAM port between instruction fetch and data access,
// one transaction in flight, MFC timeout reported as bus_err.
module mem_port_arbiter #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ack,
   output logic [DATA_W-1:0] fetch_rdata,
   input  logic              data_req,
   input  logic              data_rw,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [1:0]        data_size,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_ack,
   output logic [DATA_W-1:0] data_rdata,
   output logic              bus_err,
   output logic              ram_mfa,
   output logic              ram_rw,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [1:0]        ram_size,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic              ram_mfc
);
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
   localparam logic [1:0] S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RELEASE = 2'd2;
   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d, win_q, win_d;
   logic              mfa_q, mfa_d, rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic [DATA_W-1:0] din_q, din_d, frd_q, frd_d, drd_q, drd_d;
   logic              fack_q, fack_d, dack_q, dack_d, err_q, err_d;
   logic              gnt_data, done;
   // win/last: 1 = data requester, 0 = fetch; on a tie the one not granted last wins
   assign gnt_data = data_req & (~fetch_req | ~last_q);
   assign done     = ram_mfc | (cnt_q == CNT_MAX);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      win_d   = win_q;
      mfa_d   = mfa_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      size_d  = size_q;
      din_d   = din_q;
      frd_d   = frd_q;
      drd_d   = drd_q;
      fack_d  = 1'b0;
      dack_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: if (fetch_req | data_req) begin
            state_d = S_ACCESS;
            cnt_d   = '0;
            win_d   = gnt_data;
            last_d  = gnt_data;
            mfa_d   = 1'b1;
            rw_d    = gnt_data ? data_rw : 1'b1;
            addr_d  = gnt_data ? data_addr : fetch_addr;
            size_d  = gnt_data ? data_size : 2'b10;
            din_d   = gnt_data ? data_wdata : '0;
         end
         S_ACCESS: if (done) begin
            state_d = S_RELEASE;
            mfa_d   = 1'b0;
            fack_d  = ~win_q;
            dack_d  = win_q;
            err_d   = ~ram_mfc;
            frd_d   = (ram_mfc & ~win_q) ? ram_dout : frd_q;
            drd_d   = (ram_mfc & win_q & rw_q) ? ram_dout : drd_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         S_RELEASE: state_d = ram_mfc ? S_RELEASE : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         win_q   <= 1'b0;
         mfa_q   <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         din_q   <= '0;
         frd_q   <= '0;
         drd_q   <= '0;
         fack_q  <= 1'b0;
         dack_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         win_q   <= win_d;
         mfa_q   <= mfa_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         din_q   <= din_d;
         frd_q   <= frd_d;
         drd_q   <= drd_d;
         fack_q  <= fack_d;
         dack_q  <= dack_d;
         err_q   <= err_d;
      end
   end
   assign fetch_ack   = fack_q;
   assign fetch_rdata = frd_q;
   assign data_ack    = dack_q;
   assign data_rdata  = drd_q;
   assign bus_err     = err_q;
   assign ram_mfa     = mfa_q;
   assign ram_rw      = rw_q;
   assign ram_addr    = addr_q;
   assign ram_size    = size_q;
   assign ram_din     = din_q;
endmodule
